// File: rtl/full_adder_reg_pkg.sv
// Shared constants and helpers for the registered ripple adder.
package full_adder_reg_pkg;

  localparam int FA_MIN_WIDTH = 1;
  localparam int FA_MAX_WIDTH = 64;

  function automatic logic fa_ovf(
    input logic c_msb,
    input logic c_out
  );
    return c_msb ^ c_out;
  endfunction

endpackage

// File: rtl/full_adder_reg_fa_bit.sv
// Pure combinational 1-bit full adder cell.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder_reg.sv
// Ripple-carry adder of fa_bit cells with one output register stage.
module full_adder_reg
  import full_adder_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  localparam int RW = WIDTH + 1;

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [RW-1:0]    res;
  logic             ovf_c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    fa_bit u_fa (
      .a  (ain[i]),
      .b  (bin[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign res   = {c[WIDTH], s};
  assign ovf_c = fa_ovf(c[WIDTH-1], c[WIDTH]);

  // Result regs load only on valid so idle or X operands cannot disturb them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        {cout, sum} <= res;
        ovf         <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed and random checks of full_adder_reg at WIDTH 1, 8 and 32.
module tb_full_adder_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv;
  logic        cin;
  logic [31:0] a;
  logic [31:0] b;

  logic        s1, co1, ov1, v1;
  logic [7:0]  s8;
  logic        co8, ov8, v8;
  logic [31:0] s32;
  logic        co32, ov32, v32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder_reg #(.WIDTH(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv),
    .ain(a[0:0]), .bin(b[0:0]), .cin(cin),
    .sum(s1), .cout(co1), .ovf(ov1), .out_valid(v1)
  );

  full_adder_reg #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv),
    .ain(a[7:0]), .bin(b[7:0]), .cin(cin),
    .sum(s8), .cout(co8), .ovf(ov8), .out_valid(v8)
  );

  full_adder_reg #(.WIDTH(32)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv),
    .ain(a), .bin(b), .cin(cin),
    .sum(s32), .cout(co32), .ovf(ov32), .out_valid(v32)
  );

  // Reference: {ovf, cout, sum[31:0]} by integer add and the sign rule
  function automatic logic [33:0] fref(
    input int          w,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        c
  );
    logic [63:0] m, t;
    logic [31:0] sm;
    logic        ov;
    m  = (64'd1 << w) - 64'd1;
    t  = ({32'd0, x} & m) + ({32'd0, y} & m) + {63'd0, c};
    sm = t[31:0] & m[31:0];
    ov = (x[w-1] == y[w-1]) && (sm[w-1] != x[w-1]);
    return {ov, t[w], sm};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    iv = 1'b1; cin = 1'b1;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    #1;
    checks++;
    if ({v1, ov1, co1, s1} !== 4'b0) begin
      errors++;
      $display("FAIL reset_w1 got %b want 0", {v1, ov1, co1, s1});
    end
    checks++;
    if ({v8, ov8, co8, s8} !== 11'b0) begin
      errors++;
      $display("FAIL reset_w8 got %h want 0", {v8, ov8, co8, s8});
    end
    checks++;
    if ({v32, ov32, co32, s32} !== 35'b0) begin
      errors++;
      $display("FAIL reset_w32 got %h want 0", {v32, ov32, co32, s32});
    end
    @(negedge clk);
    iv = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({v1, v8, v32, s8, s32, co8, ov8} !== '0) begin
      errors++;
      $display("FAIL reset_idle got v=%b%b%b s8=%h s32=%h want 0",
               v1, v8, v32, s8, s32);
    end
  endtask

  task automatic test_truth;
    logic [2:0] vin [7];
    logic [2:0] vout [7];
    vin  = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
    // {ovf, cout, sum}
    vout = '{3'b000, 3'b001, 3'b110, 3'b011, 3'b010, 3'b101, 3'b000};
    for (int i = 0; i < 7; i++) begin
      iv = 1'b1;
      a = {31'd0, vin[i][2]};
      b = {31'd0, vin[i][1]};
      cin = vin[i][0];
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({v1, ov1, co1, s1} !== {1'b1, vout[i]}) begin
        errors++;
        $display("FAIL truth_%0d got v/ovf/co/s=%b want %b",
                 i, {v1, ov1, co1, s1}, {1'b1, vout[i]});
      end
    end
    iv = 1'b0;
  endtask

  task automatic test_w8_bounds;
    logic [16:0] vin [4];
    logic [9:0]  vout [4];
    vin  = '{{8'hFF, 8'h01, 1'b0}, {8'hFF, 8'hFF, 1'b1},
             {8'h7F, 8'h01, 1'b0}, {8'h80, 8'h80, 1'b0}};
    // {ovf, cout, sum}
    vout = '{{2'b01, 8'h00}, {2'b01, 8'hFF},
             {2'b10, 8'h80}, {2'b11, 8'h00}};
    for (int i = 0; i < 4; i++) begin
      iv = 1'b1;
      a = {24'd0, vin[i][16:9]};
      b = {24'd0, vin[i][8:1]};
      cin = vin[i][0];
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({v8, ov8, co8, s8} !== {1'b1, vout[i]}) begin
        errors++;
        $display("FAIL bound8_%0d got %h want %h",
                 i, {v8, ov8, co8, s8}, {1'b1, vout[i]});
      end
    end
    iv = 1'b0;
  endtask

  task automatic test_hold;
    iv = 1'b1;
    a = 32'h12; b = 32'h34; cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({v8, ov8, co8, s8} !== {3'b100, 8'h47}) begin
      errors++;
      $display("FAIL hold_load got %h want %h",
               {v8, ov8, co8, s8}, {3'b100, 8'h47});
    end
    for (int i = 0; i < 3; i++) begin
      iv = 1'b0;
      a = (i == 1) ? 'x : $urandom;
      b = $urandom;
      cin = (i == 2) ? 1'bx : 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({v8, ov8, co8, s8} !== {3'b000, 8'h47}) begin
        errors++;
        $display("FAIL hold_%0d got %h want %h",
                 i, {v8, ov8, co8, s8}, {3'b000, 8'h47});
      end
    end
  endtask

  task automatic test_reset_mid;
    iv = 1'b1;
    a = 32'h0000_00A5; b = 32'h0000_005A; cin = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if ({v8, co8, s8} !== {2'b11, 8'h00}) begin
      errors++;
      $display("FAIL mid_pre got %h want %h", {v8, co8, s8}, {2'b11, 8'h00});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({v1, v8, v32, co8, ov8, s8, co32, s32} !== '0) begin
      errors++;
      $display("FAIL mid_async got v8=%b s8=%h s32=%h want 0", v8, s8, s32);
    end
    #1;
    rst_n = 1'b1;
    a = 32'h8000_0001; b = 32'h8000_0002; cin = 1'b0;
    @(negedge clk);
    checks++;
    if ({v8, v32, s32} !== '0) begin
      errors++;
      $display("FAIL mid_quiet got v8=%b v32=%b s32=%h want 0", v8, v32, s32);
    end
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    checks++;
    if ({v32, ov32, co32, s32} !== {3'b111, 32'h0000_0003}) begin
      errors++;
      $display("FAIL mid_post got %h want %h",
               {v32, ov32, co32, s32}, {3'b111, 32'h0000_0003});
    end
  endtask

  task automatic test_random;
    logic [33:0] e1, e8, e32;
    logic        ev;
    logic        niv;
    e1 = '0; e8 = '0; e32 = '0; ev = 1'b0;
    for (int i = 0; i <= 10000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if ({v1, ov1, co1, s1} !== {ev, e1[33], e1[32], e1[0]}) begin
          errors++;
          $display("FAIL rand_w1 cyc %0d got %b want %b", i,
                   {v1, ov1, co1, s1}, {ev, e1[33], e1[32], e1[0]});
        end
        checks++;
        if ({v8, ov8, co8, s8} !== {ev, e8[33], e8[32], e8[7:0]}) begin
          errors++;
          $display("FAIL rand_w8 cyc %0d got %h want %h", i,
                   {v8, ov8, co8, s8}, {ev, e8[33], e8[32], e8[7:0]});
        end
        checks++;
        if ({v32, ov32, co32, s32} !== {ev, e32}) begin
          errors++;
          $display("FAIL rand_w32 cyc %0d got %h want %h", i,
                   {v32, ov32, co32, s32}, {ev, e32});
        end
      end
      if (i == 10000) break;
      niv = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = $urandom;
      if (i % 50 == 7) a = 32'hFFFF_FFFF;
      if (i % 50 == 9) b = 32'hFFFF_FFFF;
      cin = $urandom_range(0, 1);
      iv = niv;
      if (niv) begin
        e1  = fref(1, a, b, cin);
        e8  = fref(8, a, b, cin);
        e32 = fref(32, a, b, cin);
      end
      ev = niv;
    end
    iv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth();
    test_w8_bounds();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
